// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: opcodes, state encoding and strobe record shared by ctrl_sequencer and its decoder
package ctrl_seq_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W = 2;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_LDI = 2'd1;
  localparam logic [1:0] OP_ADDI = 2'd2;
  localparam logic [1:0] OP_ADDMV = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EX1 = 2'd1;
  localparam logic [1:0] ST_EX2 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef struct packed {
    logic ra_out;
    logic rb_out;
    logic rz_out;
    logic ra_in;
    logic rb_in;
    logic rz_in;
    logic done;
  } strobe_t;
endpackage

// File: rtl/ctrl_strobe_decode.sv
// ctrl_strobe_decode: pure state+op to strobe/immediate decoder, registered by ctrl_sequencer
module ctrl_strobe_decode
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic [1:0]        state,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] imm,
  output strobe_t           strobe,
  output logic [DATA_W-1:0] add_imm,
  output logic [DATA_W-1:0] a_imm
);
  logic ex1, ex2, ldi, add;
  assign ex1 = state == ST_EX1;
  assign ex2 = state == ST_EX2;
  assign ldi = op == OP_W'(OP_LDI);
  assign add = op == OP_W'(OP_ADDI) || op == OP_W'(OP_ADDMV);
  always_comb begin
    strobe = '0;
    strobe.ra_in = ex1 && ldi;
    strobe.ra_out = ex1 && add;
    strobe.rz_in = ex1 && add;
    strobe.rz_out = ex2;
    strobe.rb_in = ex2;
    strobe.done = state == ST_DONE;
    add_imm = (ex1 && add) ? imm : '0;
    a_imm = (ex1 && ldi) ? imm : '0;
  end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: steps one micro-instruction through T-states driving datapath strobes.
// Optional CTRL_SEQ_RETIRE_CNT_EN adds a 16-bit retire counter output.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              RAout,
  output logic              RBout,
  output logic              RZout,
  output logic              RAin,
  output logic              RBin,
  output logic              RZin,
  output logic [DATA_W-1:0] AddImmediate,
  output logic [DATA_W-1:0] RegisterAImmediate,
  output logic              busy,
  output logic              done
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);
  logic [1:0] state, n_state;
  logic [OP_W-1:0] op_q, d_op;
  logic [DATA_W-1:0] imm_q, d_imm, add_d, a_d;
  strobe_t stb_d, stb_q;
  logic accept, exec;
  assign instr_ready = state == ST_IDLE && !clear;
  assign accept = instr_valid && instr_ready;
  // Undefined opcodes fall through the NOP path straight to DONE
  assign exec = instr_op == OP_W'(OP_LDI) || instr_op == OP_W'(OP_ADDI) || instr_op == OP_W'(OP_ADDMV);
  always_comb begin
    d_op = accept ? instr_op : op_q;
    d_imm = accept ? instr_imm : imm_q;
    n_state = state == ST_IDLE ? (accept ? (exec ? ST_EX1 : ST_DONE) : ST_IDLE) :
              state == ST_EX1  ? (op_q == OP_W'(OP_ADDMV) ? ST_EX2 : ST_DONE) :
              state == ST_EX2  ? ST_DONE : ST_IDLE;
  end
  // Decode from the next state so every output lands in a flop aligned with its state
  ctrl_strobe_decode #(.DATA_W(DATA_W), .OP_W(OP_W)) u_dec (
    .state  (n_state),
    .op     (d_op),
    .imm    (d_imm),
    .strobe (stb_d),
    .add_imm(add_d),
    .a_imm  (a_d)
  );
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      op_q <= '0;
      imm_q <= '0;
      stb_q <= '0;
      AddImmediate <= '0;
      RegisterAImmediate <= '0;
      busy <= 1'b0;
    end else begin
      state <= n_state;
      op_q <= d_op;
      imm_q <= d_imm;
      stb_q <= stb_d;
      AddImmediate <= add_d;
      RegisterAImmediate <= a_d;
      busy <= n_state != ST_IDLE;
    end
  end
  assign RAout = stb_q.ra_out;
  assign RBout = stb_q.rb_out;
  assign RZout = stb_q.rz_out;
  assign RAin = stb_q.ra_in;
  assign RBin = stb_q.rb_in;
  assign RZin = stb_q.rz_in;
  assign done = stb_q.done;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) retire_cnt <= '0;
    else if (n_state == ST_DONE) retire_cnt <= retire_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: table-driven directed vectors plus reset, back-to-back and bus-exclusivity checks
module tb_ctrl_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [1:0] instr_op = 2'd0;
  logic [31:0] instr_imm = 32'd0;
  logic RAout, RBout, RZout, RAin, RBin, RZin, busy, done;
  logic [31:0] AddImmediate, RegisterAImmediate;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;

  ctrl_sequencer dut (
    .clock(clock), .clear(clear), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .RAout(RAout), .RBout(RBout), .RZout(RZout), .RAin(RAin), .RBin(RBin), .RZin(RZin),
    .AddImmediate(AddImmediate), .RegisterAImmediate(RegisterAImmediate),
    .busy(busy), .done(done)
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clock = ~clock;

  // {RAout,RBout,RZout,RAin,RBin,RZin,done,busy,instr_ready}
  logic [8:0] obs;
  assign obs = {RAout, RBout, RZout, RAin, RBin, RZin, done, busy, instr_ready};
  localparam logic [8:0] IDLE_O = 9'b000_000_0_0_1;
  localparam logic [8:0] DONE_O = 9'b000_000_1_1_0;
  localparam logic [8:0] LDI_O  = 9'b000_100_0_1_0;
  localparam logic [8:0] ADD_O  = 9'b100_001_0_1_0;
  localparam logic [8:0] MV_O   = 9'b001_010_0_1_0;
  localparam logic [8:0] ZERO_O = 9'b000_000_0_0_0;

  typedef struct {
    logic [1:0] op;
    logic [31:0] imm;
    logic [3:0][8:0] e;
    logic [31:0] add1;
    logic [31:0] a1;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] imm, input logic [8:0] e1,
                              input logic [8:0] e2, input logic [8:0] e3, input logic [8:0] e4,
                              input logic [31:0] add1, input logic [31:0] a1);
    vec_t v;
    v.op = op;
    v.imm = imm;
    v.e = {e4, e3, e2, e1};
    v.add1 = add1;
    v.a1 = a1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Bus exclusivity: never more than one *out strobe in a cycle
  always @(negedge clock) begin
    if (!clear) begin
      n_vec++;
      if ($countones({RAout, RBout, RZout}) > 1) begin
        n_err++;
        $display("FAIL out_onehot: got %b expected at most one set", {RAout, RBout, RZout});
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = mk(2'd1, 32'h5,        LDI_O,  DONE_O, IDLE_O, IDLE_O, 32'h0,        32'h5);
    vecs[1] = mk(2'd2, 32'h5,        ADD_O,  DONE_O, IDLE_O, IDLE_O, 32'h5,        32'h0);
    vecs[2] = mk(2'd3, 32'h3,        ADD_O,  MV_O,   DONE_O, IDLE_O, 32'h3,        32'h0);
    vecs[3] = mk(2'd0, 32'hDEADBEEF, DONE_O, IDLE_O, IDLE_O, IDLE_O, 32'h0,        32'h0);
    vecs[4] = mk(2'd1, 32'h0,        LDI_O,  DONE_O, IDLE_O, IDLE_O, 32'h0,        32'h0);
    vecs[5] = mk(2'd1, 32'hFFFFFFFF, LDI_O,  DONE_O, IDLE_O, IDLE_O, 32'h0,        32'hFFFFFFFF);
    vecs[6] = mk(2'd2, 32'hFFFFFFFF, ADD_O,  DONE_O, IDLE_O, IDLE_O, 32'hFFFFFFFF, 32'h0);
    vecs[7] = mk(2'd3, 32'h0,        ADD_O,  MV_O,   DONE_O, IDLE_O, 32'h0,        32'h0);
    vecs[8] = mk(2'd3, 32'hFFFFFFFF, ADD_O,  MV_O,   DONE_O, IDLE_O, 32'hFFFFFFFF, 32'h0);
    vecs[9] = mk(2'd0, 32'h0,        DONE_O, IDLE_O, IDLE_O, IDLE_O, 32'h0,        32'h0);

    // Reset state while clear is held: ready is gated by clear
    repeat (2) @(posedge clock);
    #1;
    check("reset_obs", 32'(obs), 32'(ZERO_O));
    check("reset_add", AddImmediate, 32'h0);
    check("reset_a", RegisterAImmediate, 32'h0);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    check("reset_retire", 32'(retire_cnt), 32'h0);
`endif
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("post_reset_obs", 32'(obs), 32'(IDLE_O));

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      instr_valid = 1'b1;
      instr_op = vecs[i].op;
      instr_imm = vecs[i].imm;
      #1;
      check($sformatf("v%0d_ready", i), 32'(instr_ready), 32'h1);
      step();
      instr_valid = 1'b0;
      instr_op = 2'($urandom_range(3));
      instr_imm = $urandom;
      for (int c = 0; c < 4; c++) begin
        check($sformatf("v%0d_c%0d_obs", i, c + 1), 32'(obs), 32'(vecs[i].e[c]));
        check($sformatf("v%0d_c%0d_add", i, c + 1), AddImmediate, c == 0 ? vecs[i].add1 : 32'h0);
        check($sformatf("v%0d_c%0d_aimm", i, c + 1), RegisterAImmediate, c == 0 ? vecs[i].a1 : 32'h0);
        if (c < 3) step();
      end
    end

    // Back-to-back with valid held high and op changing while busy
    @(negedge clock);
    instr_valid = 1'b1;
    instr_op = 2'd1;
    instr_imm = 32'h7;
    step();
    check("b2b_c1_obs", 32'(obs), 32'(LDI_O));
    check("b2b_c1_aimm", RegisterAImmediate, 32'h7);
    instr_op = 2'd3;
    instr_imm = 32'h9;
    step();
    check("b2b_c2_obs", 32'(obs), 32'(DONE_O));
    instr_op = 2'd2;
    instr_imm = 32'h11;
    step();
    check("b2b_c3_obs", 32'(obs), 32'(IDLE_O));
    step();
    instr_valid = 1'b0;
    check("b2b_c4_obs", 32'(obs), 32'(ADD_O));
    check("b2b_c4_add", AddImmediate, 32'h11);
    check("b2b_c4_aimm", RegisterAImmediate, 32'h0);
    step();
    check("b2b_c5_obs", 32'(obs), 32'(DONE_O));
    step();
    check("b2b_c6_obs", 32'(obs), 32'(IDLE_O));

    // Clear asserted mid-EX1 of ADDI abandons it immediately
    @(negedge clock);
    instr_valid = 1'b1;
    instr_op = 2'd2;
    instr_imm = 32'h55;
    step();
    instr_valid = 1'b0;
    check("abort_ex1_obs", 32'(obs), 32'(ADD_O));
    #2;
    clear = 1'b1;
    #1;
    check("abort_obs", 32'(obs), 32'(ZERO_O));
    check("abort_add", AddImmediate, 32'h0);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("abort_ready", 32'(obs), 32'(IDLE_O));
    step();
    check("abort_stays_idle", 32'(obs), 32'(IDLE_O));
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      instr_valid = 1'b1;
      instr_op = 2'(i);
      instr_imm = 32'h1;
      step();
      instr_valid = 1'b0;
      repeat (3) step();
    end
    check("retire_cnt", 32'(retire_cnt), 32'h4);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Control-step sequencer that sits directly upstream of `datapath` and drives all of its control and immediate inputs.
- Accepts one decoded micro-instruction (opcode + 32-bit immediate) per valid/ready handshake.
- Steps it through registered T-states, emitting the register in/out strobes and immediate buses the datapath expects, then pulses `done`.
- Replaces hand-driven testbench sequencing with synthesizable control.

Parameters:
- DATA_W, 32, width of immediates and of the AddImmediate/RegisterAImmediate buses.
- OP_W, 2, opcode width.

Ports:
- clock  input  1  system clock, rising-edge active.
- clear  input  1  asynchronous active-high reset.
- instr_valid  input  1  upstream offers an instruction.
- instr_ready  output  1  sequencer can accept this cycle.
- instr_op  input  OP_W  opcode: 0 NOP, 1 LDI (A=imm), 2 ADDI (Z=A+imm), 3 ADDMV (Z=A+imm then B=Z).
- instr_imm  input  DATA_W  immediate operand.
- RAout, RBout, RZout  output  1 each  datapath bus-drive strobes.
- RAin, RBin, RZin  output  1 each  datapath register load strobes.
- AddImmediate  output  DATA_W  adder immediate to datapath.
- RegisterAImmediate  output  DATA_W  direct load value for register A.
- busy  output  1  high from accept until `done` inclusive.
- done  output  1  one-cycle pulse when the instruction retires.

Behaviour:
- Reset (clear=1, asynchronous, any state):
  - state=IDLE.
  - All strobes 0, both immediate buses 0, busy=0, done=0.
  - Latched op/imm cleared.
  - Reset mid-instruction abandons it; no partial strobe survives past the clear edge.
- All outputs are registered (Moore, decoded into flops). No combinational path from instr_* to the strobes.
- instr_ready = (state==IDLE) && !clear. Accept = instr_valid && instr_ready at a rising edge; instr_op and instr_imm are latched on accept.
- States: IDLE, EX1, EX2, DONE.
- Transitions:
  - IDLE -> EX1 on accept with op in {LDI, ADDI, ADDMV}.
  - IDLE -> DONE on accept with op=NOP.
  - EX1 -> EX2 if op=ADDMV, else EX1 -> DONE.
  - EX2 -> DONE.
  - DONE -> IDLE unconditionally.
- Outputs per state:
  - EX1/LDI: RAin=1, RegisterAImmediate=imm.
  - EX1/ADDI and EX1/ADDMV: RAout=1, RZin=1, AddImmediate=imm.
  - EX2/ADDMV: RZout=1, RBin=1.
  - DONE: done=1.
  - Every strobe and immediate bus not listed is 0 in that state; the immediates are 0 outside their strobe cycle.
- Latency from the accept edge:
  - LDI/ADDI: strobe cycle = accept+1, done at accept+2, ready again at accept+3.
  - ADDMV: strobes at accept+1 and +2, done at accept+3.
  - NOP: done at accept+1.
- At most one *out strobe high in any cycle (bus exclusivity invariant).
- No strobe is held for more than one cycle per state.
- instr_valid held high while not ready: instr_op/instr_imm changes are ignored until the next IDLE cycle. Back-to-back instructions therefore have a 1-cycle IDLE gap minimum.
- Immediate value 0 and 0xFFFFFFFF pass through unmodified; the sequencer performs no arithmetic.
- Opcodes outside the defined set (only possible if OP_W>2) are treated as NOP.

Optional Feature:
- Macro: CTRL_SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [15:0], incremented on every done pulse, NOP included.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by clear.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package ctrl_seq_pkg holds:
  - Opcode localparams OP_NOP/OP_LDI/OP_ADDI/OP_ADDMV.
  - State encoding ST_IDLE/ST_EX1/ST_EX2/ST_DONE.
  - DATA_W default.
- One natural sub-module: ctrl_strobe_decode, the pure state+op to next-strobe-vector decoder, registered by the parent.

Test Plan:
- Reset: clear pulsed mid-EX1 of ADDI -> all strobes 0 within the same cycle, state IDLE, instr_ready=1 after clear drops.
- LDI imm=5 -> at accept+1: RAin=1 and RegisterAImmediate=0x5; all else 0; done at accept+2; with datapath attached, A=5.
- ADDI imm=5 after LDI 5 -> at accept+1: RAout=1, RZin=1, AddImmediate=0x5; Z=0xA.
- ADDMV imm=3 with A=5 -> EX1 as ADDI, EX2 RZout=1 & RBin=1, done at accept+3; B=0x8.
- Back-to-back valid held high with op changing during busy -> only the op present in the IDLE cycle is accepted; ready low for exactly the busy span; out-strobe one-hot invariant holds every cycle.
- CTRL_SEQ_RETIRE_CNT_EN: 4 instructions (NOP, LDI, ADDI, ADDMV) -> retire_cnt=4; preload-free wrap test after 65536 NOPs -> 0.
